// File: rtl/seq_div_pkg.sv
// Shared constants and state encoding for the sequential 16/8 restoring divider.
package seq_div_pkg;
  localparam int DVS_W = 8;
  localparam int DVD_W = 2 * DVS_W;
  localparam logic [DVS_W-1:0] ERR_QUOT = 8'hFF;
  localparam logic [2:0] CNT_LAST = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit, then
// conditionally subtract the divisor.
module div_step
  import seq_div_pkg::*;
(
  input  logic [DVS_W:0]   r,
  input  logic [DVS_W-1:0] divisor,
  input  logic             in_bit,
  output logic [DVS_W:0]   r_next,
  output logic             q_bit
);
  logic [DVS_W:0] r_sh;
  logic [DVS_W:0] dvs_ext;

  assign r_sh    = {r[DVS_W-1:0], in_bit};
  assign dvs_ext = {1'b0, divisor};

  // A set top bit means the true shifted value exceeds 9 bits, so it always fits the divisor.
  always_comb begin
    q_bit  = r[DVS_W] | (r_sh >= dvs_ext);
    r_next = q_bit ? (r_sh - dvs_ext) : r_sh;
  end
endmodule

// File: rtl/seq_divider16x8.sv
// Sequential 16/8 unsigned restoring divider, one quotient bit per clock.
// Optional macro DIV_EARLY_EXIT_EN: error operations skip CALC and finish one cycle after start.
module seq_divider16x8
  import seq_div_pkg::*;
(
  input  logic             clk,
  input  logic             reset_a,
  input  logic             start,
  input  logic [DVD_W-1:0] dataa,
  input  logic [DVS_W-1:0] datab,
  output logic [DVS_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             err_flag,
  output logic             busy,
  output logic             done_flag,
  output logic [1:0]       dbg_state
);
  // Handshake: start is sampled only in IDLE; done_flag pulses for one cycle when
  // quotient/remainder/err_flag become valid, and they hold until the next result.

  state_t           state, state_next;
  logic [DVS_W:0]   r, r_next;
  logic [DVS_W-1:0] dvd_lo, dvs, q_sh;
  logic [2:0]       cnt;
  logic             err_r, q_bit, err_now, load, last;

  assign err_now = (datab == '0) | (dataa[DVD_W-1:DVS_W] >= datab);
  assign last    = (state == CALC) && (cnt == CNT_LAST);

  div_step u_step (
    .r       (r),
    .divisor (dvs),
    .in_bit  (dvd_lo[DVS_W-1]),
    .r_next  (r_next),
    .q_bit   (q_bit)
  );

  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load = 1'b1;
`ifdef DIV_EARLY_EXIT_EN
          state_next = err_now ? DONE : CALC;
`else
          state_next = CALC;
`endif
        end
      end
      CALC:    if (cnt == CNT_LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) state <= IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      r         <= '0;
      dvd_lo    <= '0;
      dvs       <= '0;
      q_sh      <= '0;
      cnt       <= '0;
      err_r     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      err_flag  <= 1'b0;
    end else if (load) begin
      r      <= {1'b0, dataa[DVD_W-1:DVS_W]};
      dvd_lo <= dataa[DVS_W-1:0];
      dvs    <= datab;
      q_sh   <= '0;
      cnt    <= '0;
      err_r  <= err_now;
`ifdef DIV_EARLY_EXIT_EN
      if (err_now) begin
        quotient  <= ERR_QUOT;
        remainder <= '0;
        err_flag  <= 1'b1;
      end
`endif
    end else if (state == CALC) begin
      r      <= r_next;
      dvd_lo <= {dvd_lo[DVS_W-2:0], 1'b0};
      q_sh   <= {q_sh[DVS_W-2:0], q_bit};
      cnt    <= cnt + 3'd1;
      if (last) begin
        quotient  <= err_r ? ERR_QUOT : {q_sh[DVS_W-2:0], q_bit};
        remainder <= err_r ? '0 : r_next[DVS_W-1:0];
        err_flag  <= err_r;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign done_flag = (state == DONE);
  assign dbg_state = state;
endmodule

// File: tb/tb_seq_divider16x8.sv
// Directed and randomized bench for seq_divider16x8 against an arithmetic reference model.
module tb_seq_divider16x8;
  logic        clk = 1'b0;
  logic        reset_a = 1'b1;
  logic        start = 1'b0;
  logic [15:0] dataa = '0;
  logic [7:0]  datab = '0;
  logic [7:0]  quotient, remainder;
  logic        err_flag, busy, done_flag;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [16:0] exp_q[$];

  seq_divider16x8 dut (
    .clk       (clk),
    .reset_a   (reset_a),
    .start     (start),
    .dataa     (dataa),
    .datab     (datab),
    .quotient  (quotient),
    .remainder (remainder),
    .err_flag  (err_flag),
    .busy      (busy),
    .done_flag (done_flag),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {err, quotient, remainder} from plain integer division.
  function automatic logic [16:0] model(input logic [15:0] a, input logic [7:0] b);
    int unsigned q, r;
    if (b == 0) return {1'b1, 8'hFF, 8'h00};
    q = a / b;
    r = a % b;
    if (q > 255) return {1'b1, 8'hFF, 8'h00};
    return {1'b0, q[7:0], r[7:0]};
  endfunction

  // inj > 0: drive a competing start (0005/02) in that cycle while the operation is busy.
  task automatic run_op(input logic [15:0] a, input logic [7:0] b, input int inj, input string tag);
    logic [16:0] exp;
    int n, exp_lat;
    bit seen;
    exp = model(a, b);
    exp_q.push_back(exp);
    exp_lat = 9;
`ifdef DIV_EARLY_EXIT_EN
    if (exp[16]) exp_lat = 1;
`endif
    @(negedge clk);
    dataa = a; datab = b; start = 1'b1;
    @(posedge clk);
    n = 1;
    #1;
    start = 1'b0;
    check({tag, " busy"}, {31'd0, busy}, 32'd1);
    seen = done_flag;
    while (!seen && n < 20) begin
      @(posedge clk);
      n++;
      #1;
      if (n == inj) begin
        dataa = 16'h0005; datab = 8'h02; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      seen = done_flag;
    end
    start = 1'b0;
    check({tag, " latency"}, n, exp_lat);
    check({tag, " result"}, {15'd0, err_flag, quotient, remainder}, {15'd0, exp_q.pop_front()});
    @(posedge clk);
    #1;
    check({tag, " pulse"}, {30'd0, done_flag, busy}, 32'd0);
  endtask

  initial begin
    int dones;
    logic [7:0] b, qq, rr;
    logic [15:0] a;

    repeat (2) @(posedge clk);
    #1;
    check("reset outputs", {err_flag, busy, done_flag, quotient, remainder}, '0);
    @(negedge clk);
    reset_a = 1'b0;

    run_op(16'h03E8, 8'h07, 0, "1000/7");
    run_op(16'hFE01, 8'hFF, 0, "max quotient");
    run_op(16'h1234, 8'h00, 0, "div by zero");
    run_op(16'hFFFE, 8'hFF, 0, "overflow");

    // Start while busy must be ignored and produce no extra pulse.
    run_op(16'h0064, 8'h0A, 4, "ignored start");
    dones = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done_flag) dones++;
    end
    check("no second done", dones, 0);

    // Asynchronous reset in mid-cycle 5 of an operation.
    @(negedge clk);
    dataa = 16'h4321; datab = 8'h77; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #4;
    reset_a = 1'b1;
    #1;
    check("async reset outputs", {err_flag, busy, done_flag, quotient, remainder}, '0);
    check("async reset state", {30'd0, dbg_state}, 32'd0);
    #2;
    reset_a = 1'b0;
    dones = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done_flag) dones++;
    end
    check("no done after reset", dones, 0);
    run_op(16'h00FF, 8'h10, 0, "after reset");

    // Randomized: half constructed as valid quotients, half raw (overflow/zero likely).
    for (int i = 0; i < 30; i++) begin
      if (i % 2 == 0) begin
        b  = 8'($urandom_range(1, 255));
        qq = 8'($urandom_range(0, 255));
        rr = 8'($urandom_range(0, int'(b) - 1));
        a  = 16'(int'(qq) * int'(b) + int'(rr));
      end else begin
        a = 16'($urandom_range(0, 65535));
        b = 8'($urandom_range(0, 255));
        if (i % 5 == 0) b = 8'h00;
      end
      run_op(a, b, 0, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
